bcd_convert_scheduler: RTL

- Shares one combinational binary-to-decimal digit splitter among NUM_REQ requesters, e.g. per-player troop, land and turn counters feeding the scoreboard renderer.
- Arbitrates round-robin and registers the selected number.
- Converts it through the shared splitter.
- Holds the 3-digit result with a valid/ready output handshake tagged with the requester id.

---
 rtl/bcd_sched_pkg.sv | 21 ++
 rtl/bcd_digit_split.sv | 35 +++
 rtl/bcd_convert_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
package bcd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      HOLD    = 2'd2
   } state_e;

   typedef logic [3:0] digit_t;

   typedef struct packed {
      digit_t hundreds;
      digit_t tens;
      digit_t ones;
   } bcd_digits_t;

   localparam int unsigned DEC_MAX     = 999;
   localparam digit_t      DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/bcd_digit_split.sv
// Combinational binary-to-decimal splitter for values 0..999 (BIT <= 10),
// built from repeated compare-and-subtract of the hundreds then tens weight.
module bcd_digit_split
   import bcd_sched_pkg::*;
#(
   parameter int unsigned BIT = 10
) (
   input  logic [BIT-1:0] value_i,
   output digit_t         hundreds_o,
   output digit_t         tens_o,
   output digit_t         ones_o
);

   logic [9:0] val;
   logic [9:0] rem_h;
   digit_t     h;
   digit_t     t;

   always_comb begin
      val = 10'(value_i);
      h   = '0;
      for (int k = 9; k >= 1; k--) begin
         if (h == 4'd0 && val >= 10'(k * 100)) h = 4'(k);
      end
      rem_h = val - 10'(h) * 10'd100;
      t     = '0;
      for (int k = 9; k >= 1; k--) begin
         if (t == 4'd0 && rem_h >= 10'(k * 10)) t = 4'(k);
      end
      hundreds_o = h;
      tens_o     = t;
      ones_o     = 4'(rem_h - 10'(t) * 10'd10);
   end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one bcd_digit_split among NUM_REQ requesters.
// Define BCD_BLANK_LEADING_ZERO_EN to show leading zero digits as 4'hF.
module bcd_convert_scheduler
   import bcd_sched_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned BIT     = 10,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*BIT-1:0] req_number,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ID_W-1:0]        out_id,
   output logic [3:0]             out_hundreds,
   output logic [3:0]             out_tens,
   output logic [3:0]             out_ones,
   output logic                   out_overflow,
   output logic                   busy
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BIT-1:0]    num_q, num_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              out_valid_q, out_valid_d;
   logic [ID_W-1:0]   out_id_q, out_id_d;
   bcd_digits_t       res_q, res_d;
   logic              ovf_q, ovf_d;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   cand;
   logic              grant;
   logic              ovf_c;
   logic [BIT-1:0]    sat;
   digit_t            split_h, split_t, split_o;
   bcd_digits_t       conv;

   // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      grant     = win_found && !reset &&
                  ((state_q == IDLE) || (state_q == HOLD && out_ready));
      req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
   end

   always_comb begin
      ovf_c = (32'(num_q) > DEC_MAX);
      sat   = ovf_c ? BIT'(DEC_MAX) : num_q;
   end

   bcd_digit_split #(
      .BIT (BIT)
   ) u_split (
      .value_i    (sat),
      .hundreds_o (split_h),
      .tens_o     (split_t),
      .ones_o     (split_o)
   );

`ifdef BCD_BLANK_LEADING_ZERO_EN
   always_comb begin
      conv.hundreds = (split_h == 4'd0) ? DIGIT_BLANK : split_h;
      conv.tens     = (split_h == 4'd0 && split_t == 4'd0) ? DIGIT_BLANK : split_t;
      conv.ones     = split_o;
   end
`else
   always_comb begin
      conv.hundreds = split_h;
      conv.tens     = split_t;
      conv.ones     = split_o;
   end
`endif

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      num_d       = num_q;
      id_d        = id_q;
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      res_d       = res_q;
      ovf_d       = ovf_q;

      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
         end
         CONVERT: begin
            res_d       = conv;
            ovf_d       = ovf_c;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      // A grant is only ever raised in IDLE or in HOLD with out_ready.
      if (grant) begin
         num_d    = req_number[int'(win_idx) * int'(BIT) +: BIT];
         id_d     = win_idx;
         rr_ptr_d = ID_W'((int'(win_idx) + 1) % int'(NUM_REQ));
         state_d  = CONVERT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         num_q       <= '0;
         id_q        <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         num_q       <= num_d;
         id_q        <= id_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         res_q       <= res_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_id       = out_id_q;
   assign out_hundreds = res_q.hundreds;
   assign out_tens     = res_q.tens;
   assign out_ones     = res_q.ones;
   assign out_overflow = ovf_q;
   assign busy         = (state_q != IDLE);

endmodule
